mem_io_bridge: RTL and testbench

Unified memory and memory-mapped I/O target for the multicycle RISC-V core. Sits directly downstream of the core's single memory port (address, write data, write strobe) and returns read data combinationally. Instruction fetches and data loads share that port. Decodes each access to one of three targets: a word RAM, a 4-entry byte TX FIFO that drains through a valid/ready port, or a free-running cycle counter.

---
 rtl/mem_io_bridge.sv | 140 ++++++++++++++
 tb/tb_mem_io_bridge.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bridge.sv
// mem_io_bridge
//   Unified memory / memory-mapped I/O target for the multicycle RISC-V core.
//   One shared port (fetch + load + store). Decodes each word access to:
//     0x0000_0000 .. RAM_WORDS*4-1 : word RAM (comb read, sync write, not reset)
//     0xFFFF_0000 TXDATA : write pushes wdata[7:0] into the TX FIFO, reads 0
//     0xFFFF_0004 STATUS : {24'b0, count[3:0], 1'b0, ovf, full, empty};
//                          write with wdata[2]=1 clears ovf
//     0xFFFF_0008 CYCLES : free-running cycle counter, write loads it
//     anything else      : reads 0, writes ignored
//
// Optional feature macro: MMIO_CYCLE_COUNTER_EN
//   defined   -> CYCLES counter exists
//   undefined -> no counter flops, CYCLES behaves like unmapped space
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   adr, wdata      : byte address and store data from the core
//   mem_write       : write strobe, sampled at the rising edge
//   rdata           : combinational read data
//   tx_data/valid   : TX FIFO head byte / FIFO non-empty
//   tx_ready        : consumer accepts the head byte this cycle
//
// TX handshake: a byte transfers on every rising edge where tx_valid and
// tx_ready are both 1. tx_valid never depends on tx_ready, and tx_data is
// held stable while tx_valid=1 and tx_ready=0.

module mem_io_bridge #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [29:0] TXDATA_WADR = 30'h3FFF_C000;  // 0xFFFF_0000 >> 2
  localparam logic [29:0] STATUS_WADR = 30'h3FFF_C001;  // 0xFFFF_0004 >> 2
  localparam logic [29:0] CYCLES_WADR = 30'h3FFF_C002;  // 0xFFFF_0008 >> 2

  // Byte offset within the word is irrelevant for word-only accesses.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^adr[1:0];

  // ---------------------------------------------------------------- decode
  logic sel_ram, sel_txdata, sel_status, sel_cycles;
  assign sel_ram    = (adr[31:AW+2] == '0);
  assign sel_txdata = (adr[31:2] == TXDATA_WADR);
  assign sel_status = (adr[31:2] == STATUS_WADR);
  assign sel_cycles = (adr[31:2] == CYCLES_WADR);

  // ---------------------------------------------------------------- RAM
  logic [31:0] ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  assign ram_idx = adr[AW+1:2];

  always_ff @(posedge clk) begin
    if (mem_write && sel_ram) ram[ram_idx] <= wdata;
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          ovf;
  logic          empty, full, pop, push_req, push_ok, ovf_clr;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = tx_valid & tx_ready;
  assign push_req = mem_write & sel_txdata;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req & (~full | pop);
  assign ovf_clr  = mem_write & sel_status & wdata[2];

  assign tx_valid = ~empty;
  assign tx_data  = fifo_mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      // Clearing every entry guarantees the head reads 0 after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 8'h00;
    end else begin
      if (push_ok) begin
        fifo_mem[tail] <= wdata[7:0];
        tail           <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new overflow outranks a clear in the same cycle.
      if (push_req && !push_ok) ovf <= 1'b1;
      else if (ovf_clr)         ovf <= 1'b0;
    end
  end

  logic [3:0]  count4;
  logic [31:0] status_word;
  assign count4      = 4'(count);
  assign status_word = {24'b0, count4, 1'b0, ovf, full, empty};

  // ---------------------------------------------------------------- CYCLES
  logic [31:0] cycles_rd;
`ifdef MMIO_CYCLE_COUNTER_EN
  logic [31:0] cycles;
  always_ff @(posedge clk) begin
    if (rst)                         cycles <= '0;
    else if (mem_write && sel_cycles) cycles <= wdata;
    else                             cycles <= cycles + 32'd1;
  end
  assign cycles_rd = cycles;
`else
  assign cycles_rd = '0;
`endif

  // ---------------------------------------------------------------- read mux
  always_comb begin
    rdata = 32'h0;
    if (sel_ram)         rdata = ram[ram_idx];
    else if (sel_status) rdata = status_word;
    else if (sel_cycles) rdata = cycles_rd;
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
module tb_mem_io_bridge;

  localparam logic [31:0] A_TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLES = 32'hFFFF_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  mem_io_bridge #(.RAM_WORDS(1024), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .adr       (adr),
    .wdata     (wdata),
    .mem_write (mem_write),
    .rdata     (rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Inputs change just after the falling edge; one step crosses one rising edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    adr = a; wdata = d; mem_write = 1'b1;
    step();
    mem_write = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    adr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  // Queue model: a byte joins exp_q only when the bench expects acceptance.
  task automatic push_byte(input logic [7:0] b, input bit accepted);
    if (accepted) exp_q.push_back(b);
    bus_write(A_TXDATA, {24'h0, b});
  endtask

  task automatic drain_check(input string tag);
    tx_ready = 1'b1;
    while (exp_q.size() > 0) begin
      #1;
      check({tag, "_valid"}, {31'b0, tx_valid}, 32'd1);
      check({tag, "_data"}, {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
      step();
    end
    tx_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1; adr = 32'h0; wdata = 32'h0; mem_write = 1'b0; tx_ready = 1'b0;
    @(negedge clk);
    step();

    // Reset state (rst still high)
    read_check("rst_status", A_STATUS, 32'h0000_0001);
    read_check("rst_cycles", A_CYCLES, 32'h0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    rst = 1'b0;

    // RAM: same-cycle read during a write returns the old word
    bus_write(32'h10, 32'h1111_1111);
    adr = 32'h10; wdata = 32'hDEAD_BEEF; mem_write = 1'b1;
    #1;
    check("ram_old_during_write", rdata, 32'h1111_1111);
    step();
    mem_write = 1'b0;
    read_check("ram_rd_0x10", 32'h10, 32'hDEAD_BEEF);
    read_check("ram_rd_0x13", 32'h13, 32'hDEAD_BEEF);
    bus_write(32'h0000_1010, 32'h5A5A_5A5A);          // just past RAM: ignored
    read_check("unmapped_rd", 32'h0000_1010, 32'h0);
    read_check("ram_no_alias", 32'h10, 32'hDEAD_BEEF);
    bus_write(32'hFFC, 32'h1234_5678);                 // last RAM word
    read_check("ram_last_word", 32'hFFC, 32'h1234_5678);
    read_check("txdata_reads_0", A_TXDATA, 32'h0);

    // FIFO fill and overflow with tx_ready=0
    push_byte(8'h41, 1'b1);
    push_byte(8'h42, 1'b1);
    push_byte(8'h43, 1'b1);
    push_byte(8'h44, 1'b1);
    read_check("status_full", A_STATUS, 32'h0000_0042);
    check("head_held", {24'b0, tx_data}, 32'h41);
    push_byte(8'h45, 1'b0);
    read_check("status_ovf", A_STATUS, 32'h0000_0046);
    bus_write(A_STATUS, 32'h0000_0004);
    read_check("status_ovf_clr", A_STATUS, 32'h0000_0042);

    // Drain 0x41..0x44 on consecutive cycles
    drain_check("drain1");
    #1;
    check("drained_valid", {31'b0, tx_valid}, 32'd0);
    read_check("drained_status", A_STATUS, 32'h0000_0001);

    // Full FIFO with simultaneous push and pop
    push_byte(8'h51, 1'b1);
    push_byte(8'h52, 1'b1);
    push_byte(8'h53, 1'b1);
    push_byte(8'h54, 1'b1);
    tx_ready = 1'b1;
    #1;
    check("sim_head", {24'b0, tx_data}, {24'b0, exp_q.pop_front()});
    push_byte(8'h55, 1'b1);
    tx_ready = 1'b0;
    read_check("sim_status", A_STATUS, 32'h0000_0042);
    drain_check("drain2");
    read_check("drain2_status", A_STATUS, 32'h0000_0001);

    // CYCLES load and wrap
    bus_write(A_CYCLES, 32'hFFFF_FFFE);
`ifdef MMIO_CYCLE_COUNTER_EN
    read_check("cyc_load", A_CYCLES, 32'hFFFF_FFFE);
    step();
    read_check("cyc_inc", A_CYCLES, 32'hFFFF_FFFF);
    step();
    read_check("cyc_wrap", A_CYCLES, 32'h0000_0000);
`else
    read_check("cyc_off_0", A_CYCLES, 32'h0);
    step();
    read_check("cyc_off_1", A_CYCLES, 32'h0);
`endif

    // Reset mid-operation with 3 bytes queued
    bus_write(32'h20, 32'hCAFE_F00D);
    push_byte(8'h61, 1'b1);
    push_byte(8'h62, 1'b1);
    push_byte(8'h63, 1'b1);
    read_check("pre_rst_status", A_STATUS, 32'h0000_0030);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", {31'b0, tx_valid}, 32'd0);
    check("mid_rst_data", {24'b0, tx_data}, 32'd0);
    read_check("mid_rst_status", A_STATUS, 32'h0000_0001);
    read_check("mid_rst_cycles", A_CYCLES, 32'h0);
    read_check("mid_rst_ram", 32'h20, 32'hCAFE_F00D);
    read_check("mid_rst_ram2", 32'h10, 32'hDEAD_BEEF);

    // FIFO works again after reset
    push_byte(8'h71, 1'b1);
    drain_check("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
